y_fetch_pc: RTL and testbench
=============================

Name: y_fetch_pc

Overview:
- Program-counter / fetch-sequencing stage that drives the 2:1 next-PC mux path and the decode stage.
- Holds the PC register and selects among three next-PC sources: sequential (PC+STEP), branch target, jump target.
- Presents the current PC to decode through a valid/ready handshake.
- Inserts a one-cycle bubble after any redirect and counts accepted fetches.

Parameters:
- WIDTH, 32, PC and target width in bits.
- RESET_PC, 0, PC value loaded on reset.
- STEP, 4, sequential increment in bytes.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- branch  input  1  branch-taken redirect request, sampled at clk edge.
- branch_target  input  WIDTH  branch destination.
- jump  input  1  jump redirect request, sampled at clk edge.
- jump_target  input  WIDTH  jump destination.
- out_ready  input  1  decode can accept the current PC.
- out_valid  output  1  out_pc is a valid fetch.
- out_pc  output  WIDTH  current PC presented to decode.
- pc_seq  output  WIDTH  combinational pc+STEP, modulo 2^WIDTH, for the mux a-input.
- fetch_count  output  CNT_W  number of accepted handshakes, wraps.
- fault  output  1  misalignment fault; present only when the optional feature is compiled in, tied 0 otherwise.

Behaviour:
- Reset (async assert, sync deassert by design):
  - pc=RESET_PC, state=IDLE, out_valid=0, fetch_count=0, fault=0.
  - Reset mid-operation discards any pending redirect immediately.
- States: IDLE, RUN, BUBBLE, HALT (HALT only with the optional feature).
- out_valid=1 only in RUN (registered state decode); out_pc=pc in all states.
- Handshake: fire = out_valid & out_ready.
  - out_pc is held stable while out_valid=1 and out_ready=0.
- Next-PC priority, evaluated every edge: jump > branch > fire > hold.
  - jump=1: pc<=jump_target, state<=BUBBLE (branch ignored).
  - else branch=1: pc<=branch_target, state<=BUBBLE.
  - else fire: pc<=pc+STEP (wraps to 0 past 2^WIDTH-1), stay RUN.
  - else pc holds.
- Transitions:
  - IDLE->RUN after one cycle, unless a redirect occurs (-> BUBBLE).
  - RUN->BUBBLE on redirect.
  - BUBBLE->RUN next cycle, unless another redirect occurs (stay BUBBLE, new target wins).
- Redirect coincident with fire:
  - The handshake still completes: fetch_count increments.
  - pc takes the redirect target, not pc+STEP.
- fetch_count increments by 1 on every fire, wraps at 2^CNT_W.
- Redirects in IDLE or BUBBLE do not change fetch_count.
- Latency: redirect asserted at edge N -> out_pc = target after edge N, out_valid=1 after edge N+1.

Optional Feature:
- Macro: Y_FETCH_ALIGN_CHECK_EN.
- Defined:
  - Any redirect target with bits [1:0] != 0 sets state<=HALT, fault<=1, pc<=that target.
  - HALT has out_valid=0, ignores all inputs and is left only by reset.
  - pc+STEP is never checked.
- Undefined:
  - No HALT state; fault tied 0.
  - Any target is accepted unchecked.

Test Plan:
- Reset/startup: reset_n low for 2 cycles, then high, out_ready=1 -> cycle 1 out_valid=0 pc=0; then out_pc=0,4,8,12 on consecutive cycles; fetch_count=3 after three fires.
- Backpressure: in RUN at pc=8, out_ready=0 for 3 cycles -> out_pc stays 8, out_valid=1, fetch_count unchanged; out_ready=1 -> next cycle pc=12.
- Redirect priority: at pc=16, jump=1 (jump_target=0x100) and branch=1 (branch_target=0x40) in the same cycle -> pc=0x100, one out_valid=0 bubble, then out_pc=0x100 valid; fetch_count +1 if out_ready was 1.
- Back-to-back redirect: branch to 0x20, then branch to 0x80 during the BUBBLE -> out_pc never valid at 0x20; valid at 0x80 after one more bubble.
- Wrap: WIDTH=8, RESET_PC=0xFC -> after one fire pc=0x00, pc_seq=0x04; CNT_W=2 -> fetch_count wraps 3->0 on the fourth fire.
- Align check (macro defined): jump_target=0x102 -> fault=1, out_valid=0 indefinitely with out_ready=1; assert reset_n low mid-HALT -> fault=0, pc=RESET_PC immediately (asynchronously).

Source files
------------

// File: rtl/y_fetch_pc.sv
// ---------------------------------------------------------------------------
// y_fetch_pc -- program-counter / fetch-sequencing stage.
//
// Holds the PC and picks the next PC from three sources: sequential
// (pc + STEP), branch target or jump target. Priority: jump > branch >
// accepted fetch > hold. The current PC is offered to decode through a
// valid/ready handshake. Every redirect inserts a one-cycle bubble.
// Accepted handshakes are counted.
//
// Handshake: fire = out_valid & out_ready. While out_valid=1 and
// out_ready=0, out_pc is held stable. out_valid is a decode of the
// registered state (RUN only), so it never depends combinationally on
// out_ready.
//
// Optional feature, macro Y_FETCH_ALIGN_CHECK_EN: a redirect target with
// bits [1:0] != 0 enters HALT and raises fault. HALT is left only by
// reset. Without the macro there is no HALT state, fault is tied 0 and
// every target is accepted. Requires WIDTH >= 2.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   branch         branch-taken redirect request
//   branch_target  branch destination
//   jump           jump redirect request (wins over branch)
//   jump_target    jump destination
//   out_ready      decode can accept the current PC
//   out_valid      out_pc is a valid fetch
//   out_pc         current PC
//   pc_seq         combinational pc + STEP (wraps)
//   fetch_count    number of accepted handshakes (wraps)
//   fault          misalignment fault (0 without the optional feature)
//   state_dbg      current FSM state encoding, for observation
// ---------------------------------------------------------------------------
module y_fetch_pc #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0,
    parameter int                 STEP     = 4,
    parameter int                 CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] pc_seq,
    output logic [CNT_W-1:0] fetch_count,
    output logic             fault,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
`ifdef Y_FETCH_ALIGN_CHECK_EN
        , HALT = 2'd3
`endif
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pc, pc_n;
    logic [WIDTH-1:0] target;
    logic             redirect;
    logic             fire;
    logic             halted;

    assign out_valid = (state == RUN);
    assign out_pc    = pc;
    assign pc_seq    = pc + WIDTH'(STEP);
    assign fire      = out_valid & out_ready;
    assign redirect  = jump | branch;
    assign target    = jump ? jump_target : branch_target;
    assign state_dbg = state;

`ifdef Y_FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_n;
    assign halted = (state == HALT);
    assign fault  = fault_q;
`else
    assign halted = 1'b0;
    assign fault  = 1'b0;
`endif

    // Next-state / next-PC selection.
    always_comb begin
        state_n = state;
        pc_n    = pc;
`ifdef Y_FETCH_ALIGN_CHECK_EN
        fault_n = fault_q;
`endif
        if (!halted) begin
            if (redirect) begin
                pc_n    = target;
                state_n = BUBBLE;
`ifdef Y_FETCH_ALIGN_CHECK_EN
                if (target[1:0] != 2'b00) begin
                    state_n = HALT;
                    fault_n = 1'b1;
                end
`endif
            end else begin
                // IDLE and BUBBLE both last exactly one cycle; RUN stays.
                state_n = RUN;
                if (fire) begin
                    pc_n = pc_seq;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    // A handshake completes even when a redirect arrives in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= '0;
        end else if (fire) begin
            fetch_count <= fetch_count + CNT_W'(1);
        end
    end

`ifdef Y_FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_n;
        end
    end
`endif

endmodule

// File: tb/tb_y_fetch_pc.sv
// ---------------------------------------------------------------------------
// tb_y_fetch_pc -- directed bench for y_fetch_pc.
// Main instance uses default parameters; a second instance uses WIDTH=8,
// RESET_PC=0xFC, CNT_W=2 for the PC and counter wrap cases.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_y_fetch_pc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        branch, jump, out_ready;
    logic [31:0] branch_target, jump_target;
    logic        out_valid, fault;
    logic [31:0] out_pc, pc_seq;
    logic [15:0] fetch_count;
    logic [1:0]  state_dbg;

    logic        w_reset_n, w_ready, w_zero;
    logic [7:0]  w_target;
    logic        w_valid, w_fault;
    logic [7:0]  w_pc, w_pc_seq;
    logic [1:0]  w_count, w_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y_fetch_pc dut (
        .clk(clk), .reset_n(reset_n),
        .branch(branch), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .pc_seq(pc_seq), .fetch_count(fetch_count), .fault(fault),
        .state_dbg(state_dbg)
    );

    y_fetch_pc #(.WIDTH(8), .RESET_PC(8'hFC), .STEP(4), .CNT_W(2)) u_wrap (
        .clk(clk), .reset_n(w_reset_n),
        .branch(w_zero), .branch_target(w_target),
        .jump(w_zero), .jump_target(w_target),
        .out_ready(w_ready), .out_valid(w_valid), .out_pc(w_pc),
        .pc_seq(w_pc_seq), .fetch_count(w_count), .fault(w_fault),
        .state_dbg(w_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Checks the main instance's valid / pc / count together.
    task automatic chk3(input string tag, input logic v, input logic [31:0] pc, input logic [15:0] cnt);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".count"}, {16'd0, fetch_count}, {16'd0, cnt});
    endtask

    initial begin
        reset_n = 1'b0; w_reset_n = 1'b0;
        branch = 1'b0; jump = 1'b0; out_ready = 1'b1;
        branch_target = '0; jump_target = '0;
        w_ready = 1'b1; w_zero = 1'b0; w_target = '0;

        // Reset / startup
        step(2);
        chk3("rst", 1'b0, 32'h0, 16'd0);
        check("rst.fault", {31'd0, fault}, 32'd0);
        check("rst.pc_seq", pc_seq, 32'h4);
        check("rst.state", {30'd0, state_dbg}, 32'd0);
        reset_n = 1'b1;
        chk3("idle", 1'b0, 32'h0, 16'd0);
        step(); chk3("run0", 1'b1, 32'h0, 16'd0);
        step(); chk3("run4", 1'b1, 32'h4, 16'd1);
        step(); chk3("run8", 1'b1, 32'h8, 16'd2);

        // Backpressure at pc=8
        out_ready = 1'b0;
        step(); chk3("bp1", 1'b1, 32'h8, 16'd2);
        step(); chk3("bp2", 1'b1, 32'h8, 16'd2);
        step(); chk3("bp3", 1'b1, 32'h8, 16'd2);
        out_ready = 1'b1;
        step(); chk3("run12", 1'b1, 32'hC, 16'd3);
        step(); chk3("run16", 1'b1, 32'h10, 16'd4);

        // Jump and branch together at pc=16 with a completing handshake
        jump = 1'b1; jump_target = 32'h100;
        branch = 1'b1; branch_target = 32'h40;
        step(); chk3("prio", 1'b0, 32'h100, 16'd5);
        jump = 1'b0; branch = 1'b0;
        step(); chk3("prio.run", 1'b1, 32'h100, 16'd5);

        // Back-to-back branches: 0x20 never becomes valid
        branch = 1'b1; branch_target = 32'h20;
        step(); chk3("b2b1", 1'b0, 32'h20, 16'd6);
        branch_target = 32'h80;
        step(); chk3("b2b2", 1'b0, 32'h80, 16'd6);
        branch = 1'b0;
        step(); chk3("b2b.run", 1'b1, 32'h80, 16'd6);
        step(); chk3("b2b.seq", 1'b1, 32'h84, 16'd7);

        // Redirect while stalled: no handshake, count unchanged
        out_ready = 1'b0; jump = 1'b1; jump_target = 32'h200;
        step(); chk3("stall.jmp", 1'b0, 32'h200, 16'd7);
        jump = 1'b0; out_ready = 1'b1;
        step(); chk3("stall.run", 1'b1, 32'h200, 16'd7);
        check("stall.pc_seq", pc_seq, 32'h204);

        // Async reset mid-cycle with a pending redirect
        branch = 1'b1; branch_target = 32'h3000;
        #2 reset_n = 1'b0;
        #1 chk3("arst", 1'b0, 32'h0, 16'd0);
        step(); chk3("arst.hold", 1'b0, 32'h0, 16'd0);
        branch = 1'b0;
        reset_n = 1'b1;
        step(); chk3("arst.run", 1'b1, 32'h0, 16'd0);

        // Misaligned jump target
        jump = 1'b1; jump_target = 32'h102;
`ifdef Y_FETCH_ALIGN_CHECK_EN
        step(); chk3("halt", 1'b0, 32'h102, 16'd1);
        check("halt.fault", {31'd0, fault}, 32'd1);
        jump = 1'b0; branch = 1'b1; branch_target = 32'h40;
        step(3); chk3("halt.stay", 1'b0, 32'h102, 16'd1);
        check("halt.fault2", {31'd0, fault}, 32'd1);
        branch = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk3("halt.rst", 1'b0, 32'h0, 16'd0);
        check("halt.rst.fault", {31'd0, fault}, 32'd0);
        step(); reset_n = 1'b1;
`else
        step(); chk3("mis", 1'b0, 32'h102, 16'd1);
        check("mis.fault", {31'd0, fault}, 32'd0);
        jump = 1'b0;
        step(); chk3("mis.run", 1'b1, 32'h102, 16'd1);
        step(); chk3("mis.seq", 1'b1, 32'h106, 16'd2);
`endif

        // Wrap instance: PC wraps past 0xFF, counter wraps 3 -> 0
        w_reset_n = 1'b1;
        check("w.idle.pc", {24'd0, w_pc}, 32'hFC);
        check("w.idle.valid", {31'd0, w_valid}, 32'd0);
        check("w.idle.seq", {24'd0, w_pc_seq}, 32'h00);
        step(); check("w.run.pc", {24'd0, w_pc}, 32'hFC);
        step(); check("w.wrap.pc", {24'd0, w_pc}, 32'h00);
        check("w.wrap.seq", {24'd0, w_pc_seq}, 32'h04);
        check("w.cnt1", {30'd0, w_count}, 32'd1);
        step(2); check("w.cnt3", {30'd0, w_count}, 32'd3);
        step(); check("w.cnt0", {30'd0, w_count}, 32'd0);
        check("w.pc0c", {24'd0, w_pc}, 32'h0C);
        check("w.fault", {31'd0, w_fault}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
